// File: rtl/pm_loader.sv
`default_nettype none
// pm_loader: takes a nibble-serial LEN / data / CHK frame from a host, writes it to program memory
// and holds the MPU in reset until the checksum verifies.  Rev 1.0
module pm_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              load_abort,
  input  logic [3:0]        host_nibble,
  input  logic              host_valid,
  output logic              host_ready,
  output logic              pm_wr_en,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              mpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] LEN_HI = 4'd1;
  localparam logic [3:0] LEN_LO = 4'd2;
  localparam logic [3:0] DAT_HI = 4'd3;
  localparam logic [3:0] DAT_LO = 4'd4;
  localparam logic [3:0] WRITE  = 4'd5;
  localparam logic [3:0] CHK_HI = 4'd6;
  localparam logic [3:0] CHK_LO = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;
  localparam logic [3:0] ERROR  = 4'd9;

  localparam int CMP_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [3:0]        state;
  logic [3:0]        hi_nib;
  logic [DATA_W-1:0] len;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] csum;
  logic              xfer;
  logic              busy;
  logic              last;

  assign host_ready = state inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO};
  assign xfer       = host_valid & host_ready;
  assign busy       = !(state inside {IDLE, DONE, ERROR});
  assign last       = CMP_W'(addr) == CMP_W'(len);

  // Status outputs decode straight from state so reset clears them without waiting for a clock.
  assign pm_wr_en  = (state == WRITE);
  assign mpu_reset = busy | (state == ERROR);
  assign load_done = (state == DONE);
  assign load_err  = (state == ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hi_nib     <= '0;
      len        <= '0;
      addr       <= '0;
      csum       <= '0;
      pm_wr_addr <= '0;
      pm_wr_data <= '0;
    end else if (!busy) begin
      if (load_req) begin
        state <= LEN_HI;
        addr  <= '0;
        csum  <= '0;
      end
    end else if (load_abort) begin
      state <= ERROR;
    end else begin
      case (state)
        LEN_HI: if (xfer) begin
          hi_nib <= host_nibble;
          state  <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          len   <= {hi_nib, host_nibble};
          state <= DAT_HI;
        end
        DAT_HI: if (xfer) begin
          hi_nib <= host_nibble;
          state  <= DAT_LO;
        end
        DAT_LO: if (xfer) begin
          pm_wr_addr <= addr;
          pm_wr_data <= {hi_nib, host_nibble};
          state      <= WRITE;
        end
        WRITE: begin
          csum <= csum + pm_wr_data;
          // Stop on the last address rather than incrementing, so LEN=255 never wraps.
          if (last) begin
            state <= CHK_HI;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= DAT_HI;
          end
        end
        CHK_HI: if (xfer) begin
          hi_nib <= host_nibble;
          state  <= CHK_LO;
        end
        CHK_LO: if (xfer) begin
          state <= ({hi_nib, host_nibble} == csum) ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pm_loader.sv
`default_nettype none
// tb_pm_loader: table of frames with hand-computed checksums, plus abort, full-depth and async reset sequences.
module tb_pm_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic       load_abort;
  logic [3:0] host_nibble;
  logic       host_valid;
  logic       host_ready;
  logic       pm_wr_en;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       mpu_reset;
  logic       load_done;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         dbl = 0;
  logic       prev_en = 1'b0;

  typedef struct {
    logic [7:0]       len;
    logic [3:0][7:0]  d;      // d[0] is the first data byte
    logic [7:0]       chk;
    int               gap;
    logic             exp_done;
  } vec_t;

  vec_t tbl [6];

  pm_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .load_abort (load_abort),
    .host_nibble(host_nibble),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .pm_wr_en   (pm_wr_en),
    .pm_wr_addr (pm_wr_addr),
    .pm_wr_data (pm_wr_data),
    .mpu_reset  (mpu_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Record every write strobe; a strobe seen on two consecutive cycles is a double.
  always @(negedge clk) begin
    if (pm_wr_en) begin
      wa_q.push_back(pm_wr_addr);
      wd_q.push_back(pm_wr_data);
      if (prev_en) dbl++;
    end
    prev_en = pm_wr_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    dbl = 0;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic pulse_abort();
    load_abort = 1'b1;
    @(posedge clk); #1;
    load_abort = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    int t = 0;
    host_nibble = n;
    host_valid  = 1'b1;
    while (!host_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!host_ready) check("ready_timeout", 32'(host_ready), 32'd1);
    @(posedge clk); #1;
    host_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    send_nib(b[7:4], gap);
    send_nib(b[3:0], gap);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    clear_log();
    pulse_req();
    send_byte(v.len, v.gap);
    for (int k = 0; k <= int'(v.len); k++) send_byte(v.d[k], v.gap);
    send_byte(v.chk, v.gap);
    check({tag, "_done"},   32'(load_done), 32'(v.exp_done));
    check({tag, "_err"},    32'(load_err),  32'(!v.exp_done));
    check({tag, "_mpu"},    32'(mpu_reset), 32'(!v.exp_done));
    check({tag, "_wcount"}, 32'(wa_q.size()), 32'(v.len) + 32'd1);
    check({tag, "_dbl"},    32'(dbl), 32'd0);
    for (int k = 0; k < wa_q.size() && k < 4; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 32'(wa_q[k]), 32'(k));
      check($sformatf("%s_data%0d", tag, k), 32'(wd_q[k]), 32'(v.d[k]));
    end
  endtask

  initial begin
    int errs;

    // A5+3C+01 = E2; 80+80+FF+02 = 0x201 -> 01
    tbl[0] = '{len: 8'h02, d: {8'h00, 8'h01, 8'h3C, 8'hA5}, chk: 8'hE2, gap: 0, exp_done: 1'b1};
    tbl[1] = '{len: 8'h02, d: {8'h00, 8'h01, 8'h3C, 8'hA5}, chk: 8'hFF, gap: 0, exp_done: 1'b0};
    tbl[2] = '{len: 8'h02, d: {8'h00, 8'h01, 8'h3C, 8'hA5}, chk: 8'hE2, gap: 2, exp_done: 1'b1};
    tbl[3] = '{len: 8'h00, d: {8'h00, 8'h00, 8'h00, 8'h7F}, chk: 8'h7F, gap: 0, exp_done: 1'b1};
    tbl[4] = '{len: 8'h03, d: {8'h02, 8'hFF, 8'h80, 8'h80}, chk: 8'h01, gap: 1, exp_done: 1'b1};
    tbl[5] = '{len: 8'h00, d: {8'h00, 8'h00, 8'h00, 8'h00}, chk: 8'h01, gap: 0, exp_done: 1'b0};

    reset       = 1'b1;
    load_req    = 1'b0;
    load_abort  = 1'b0;
    host_nibble = 4'h0;
    host_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(host_ready), 32'd0);
    check("rst_wr_en", 32'(pm_wr_en),   32'd0);
    check("rst_mpu",   32'(mpu_reset),  32'd0);
    check("rst_done",  32'(load_done),  32'd0);
    check("rst_err",   32'(load_err),   32'd0);
    check("rst_waddr", 32'(pm_wr_addr), 32'd0);
    check("rst_wdata", 32'(pm_wr_data), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    pulse_abort();
    check("idle_abort_err", 32'(load_err), 32'd0);
    check("idle_abort_mpu", 32'(mpu_reset), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Full depth: data byte = address, sum 0..255 = 0x7F80
    clear_log();
    pulse_req();
    send_byte(8'hFF, 0);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
    send_byte(8'h80, 0);
    errs = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 8'(i) || wd_q[i] !== 8'(i)) errs++;
    check("full_wcount", 32'(wa_q.size()), 32'd256);
    check("full_seq",    32'(errs), 32'd0);
    check("full_done",   32'(load_done), 32'd1);
    check("full_mpu",    32'(mpu_reset), 32'd0);
    check("full_dbl",    32'(dbl), 32'd0);

    // Abort after the second data byte; a mid-load load_req must be ignored
    clear_log();
    pulse_req();
    send_byte(8'h03, 0);
    pulse_req();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(posedge clk); #1;
    host_nibble = 4'h4;
    host_valid  = 1'b1;
    pulse_abort();
    host_valid = 1'b0;
    check("abort_err",    32'(load_err),  32'd1);
    check("abort_mpu",    32'(mpu_reset), 32'd1);
    check("abort_done",   32'(load_done), 32'd0);
    check("abort_ready",  32'(host_ready), 32'd0);
    check("abort_wcount", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("abort_addr1", 32'(wa_q[1]), 32'd1);
      check("abort_data1", 32'(wd_q[1]), 32'h22);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("error_hold", 32'(load_err), 32'd1);
    run_vec(tbl[0], "restart");

    pulse_abort();
    check("done_abort_done", 32'(load_done), 32'd1);
    check("done_abort_err",  32'(load_err),  32'd0);

    // Async reset in the middle of the DAT_LO cycle
    clear_log();
    pulse_req();
    send_byte(8'h00, 0);
    send_nib(4'h5, 0);
    host_nibble = 4'h6;
    host_valid  = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("areset_ready", 32'(host_ready), 32'd0);
    check("areset_wr_en", 32'(pm_wr_en),   32'd0);
    check("areset_mpu",   32'(mpu_reset),  32'd0);
    check("areset_done",  32'(load_done),  32'd0);
    check("areset_err",   32'(load_err),   32'd0);
    check("areset_waddr", 32'(pm_wr_addr), 32'd0);
    check("areset_wdata", 32'(pm_wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    host_valid = 1'b0;
    reset      = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("areset_nowrite", 32'(wa_q.size()), 32'd0);
    check("areset_idle_mpu", 32'(mpu_reset), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
